// File: rtl/icache_loader_pkg.sv
// ----------------------------------------------------------------------------
// icache_loader_pkg
// Shared types for the instruction-cache loader slice.
//   address_t     : icache write index (5 bits, up to 32 instructions)
//   instruction_t : one 32-bit instruction word
//   byte_idx_t    : position of a byte inside an instruction (0..3)
//   lane_of()     : maps the arrival order of a byte to its byte lane
// ----------------------------------------------------------------------------
package icache_loader_pkg;

  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 32;

  typedef logic [ADDR_W-1:0]  address_t;
  typedef logic [INSTR_W-1:0] instruction_t;
  typedef logic [1:0]         byte_idx_t;

  // Arrival index 0 lands in bits [7:0] (little endian) or [31:24] (big endian).
  function automatic byte_idx_t lane_of(input byte_idx_t cnt, input bit big_endian);
    return big_endian ? byte_idx_t'(2'd3 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/icache_loader_if.sv
// ----------------------------------------------------------------------------
// icache_loader_if
// Bundles the loader's control inputs, byte stream and icache write port.
//   master : host / byte source side (drives start, abort, in_valid, in_data)
//   slave  : the loader (drives in_ready, write*, busy, done)
// ----------------------------------------------------------------------------
interface icache_loader_if;
  import icache_loader_pkg::*;

  logic         start;
  logic         abort;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         write;
  address_t     write_addr;
  instruction_t write_data;
  logic         busy;
  logic         done;

  modport master (
    output start, abort, in_valid, in_data,
    input  in_ready, write, write_addr, write_data, busy, done
  );

  modport slave (
    input  start, abort, in_valid, in_data,
    output in_ready, write, write_addr, write_data, busy, done
  );

endinterface

// File: rtl/icache_loader_byte_packer.sv
// ----------------------------------------------------------------------------
// byte_packer
// Assembles four consecutive accepted bytes into one 32-bit instruction.
//   clk, nrst  : clock, asynchronous active-low reset
//   clear      : drop any partial word and restart at byte 0
//   accept     : byte_in is consumed this cycle
//   byte_in    : incoming byte
//   last_byte  : the byte being offered now is the 4th of its word
//   word       : assembly register including the byte accepted this cycle,
//                so it is the complete word when accept && last_byte
// ----------------------------------------------------------------------------
module byte_packer
  import icache_loader_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clear,
  input  logic         accept,
  input  logic [7:0]   byte_in,
  output logic         last_byte,
  output instruction_t word
);

  byte_idx_t    cnt_q, cnt_d;
  instruction_t asm_q, asm_d;
  byte_idx_t    lane;

  assign lane = lane_of(cnt_q, BIG_ENDIAN);

  // Each lane either takes the incoming byte or keeps its held value.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign asm_d[8*gi +: 8] = (accept && (lane == byte_idx_t'(gi))) ? byte_in
                                                                     : asm_q[8*gi +: 8];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 2'd1;   // wraps 3 -> 0
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= clear ? '0 : asm_d;
    end
  end

  assign last_byte = (cnt_q == 2'd3);
  assign word      = asm_d;

endmodule

// File: rtl/icache_loader.sv
// ----------------------------------------------------------------------------
// icache_loader
// Streams bytes into 32-bit instructions and writes NUM_WORDS of them into the
// icache starting at index 0.
//   clk   : clock, rising edge
//   nrst  : asynchronous active-low reset
//   bus   : icache_loader_if.slave
//           start/abort        run control (abort wins over everything)
//           in_valid/in_data   byte stream, in_ready = accept this cycle
//           write/write_addr/write_data  registered icache write port
//           busy (LOAD), done (DONE)
// ----------------------------------------------------------------------------
module icache_loader
  import icache_loader_pkg::*;
#(
  parameter int NUM_WORDS  = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic               clk,
  input  logic               nrst,
  icache_loader_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_t;

  localparam address_t LAST_ADDR = address_t'(NUM_WORDS - 1);

  state_t       state_q, state_d;
  address_t     word_cnt_q, word_cnt_d;
  logic         write_q, write_d;
  address_t     write_addr_q, write_addr_d;
  instruction_t write_data_q, write_data_d;

  logic         in_ready;
  logic         accept;
  logic         clear;
  logic         last_byte;
  instruction_t packed_word;

  // Kept outside the FSM block so the packer output feeding write_data_d
  // has no combinational path back into its own inputs.
  assign in_ready = (state_q == ST_LOAD) && !bus.abort;
  assign accept   = in_ready && bus.in_valid;
  // Partial words are dropped on abort and on every (re)start.
  assign clear    = bus.abort || (bus.start && (state_q != ST_LOAD));

  byte_packer #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_byte_packer (
    .clk       (clk),
    .nrst      (nrst),
    .clear     (clear),
    .accept    (accept),
    .byte_in   (bus.in_data),
    .last_byte (last_byte),
    .word      (packed_word)
  );

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    write_d      = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;

    if (bus.abort) begin
      state_d    = ST_IDLE;
      word_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d    = ST_LOAD;
            word_cnt_d = '0;
          end
        end
        ST_LOAD: begin
          if (accept && last_byte) begin
            write_d      = 1'b1;
            write_addr_d = word_cnt_q;
            write_data_d = packed_word;
            word_cnt_d   = word_cnt_q + address_t'(1);
            if (word_cnt_q == LAST_ADDR) begin
              state_d = ST_DONE;
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          word_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= '0;
      write_q      <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      write_q      <= write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.write      = write_q;
  assign bus.write_addr = write_addr_q;
  assign bus.write_data = write_data_q;
  assign bus.busy       = (state_q == ST_LOAD);
  assign bus.done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_icache_loader.sv
// ----------------------------------------------------------------------------
// tb_icache_loader
// Directed bench: dut_a (32 words, little endian), dut_b (4 words, big endian).
// ----------------------------------------------------------------------------
module tb_icache_loader;
  import icache_loader_pkg::*;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  icache_loader_if bus_a ();
  icache_loader_if bus_b ();

  icache_loader #(.NUM_WORDS(32), .BIG_ENDIAN(1'b0)) dut_a (
    .clk (clk), .nrst (nrst), .bus (bus_a)
  );
  icache_loader #(.NUM_WORDS(4), .BIG_ENDIAN(1'b1)) dut_b (
    .clk (clk), .nrst (nrst), .bus (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // icache models, filled from the write port
  instruction_t mem_a [32];
  instruction_t mem_b [4];
  int wr_cnt_a = 0;
  int wr_cnt_b = 0;

  always @(negedge clk) begin
    if (bus_a.write === 1'b1) begin
      mem_a[bus_a.write_addr] = bus_a.write_data;
      wr_cnt_a++;
      $display("dut_a write addr=%0d data=%08h", bus_a.write_addr, bus_a.write_data);
    end
    if (bus_b.write === 1'b1) begin
      mem_b[bus_b.write_addr[1:0]] = bus_b.write_data;
      wr_cnt_b++;
      $display("dut_b write addr=%0d data=%08h", bus_b.write_addr, bus_b.write_data);
    end
  end

  function automatic logic [7:0] byte_f(input int j);
    return 8'(j * 7 + 3);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #3;
    n_checks++;
    if ({bus_a.in_ready, bus_a.write, bus_a.busy, bus_a.done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_a_ctrl: got %b expected 0000",
               {bus_a.in_ready, bus_a.write, bus_a.busy, bus_a.done});
    end
    n_checks++;
    if (bus_a.write_addr !== 5'd0 || bus_a.write_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_a_port: got %0d/%08h expected 0/00000000",
               bus_a.write_addr, bus_a.write_data);
    end
    n_checks++;
    if ({bus_b.in_ready, bus_b.write, bus_b.busy, bus_b.done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_b_ctrl: got %b expected 0000",
               {bus_b.in_ready, bus_b.write, bus_b.busy, bus_b.done});
    end
    tick();
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    logic [7:0] bs [4];
    bs = '{8'h78, 8'h56, 8'h34, 8'h12};
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    n_checks++;
    if (bus_a.busy !== 1'b1) begin
      n_fail++; $display("FAIL single_busy: got %b expected 1", bus_a.busy);
    end
    for (int i = 0; i < 4; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = bs[i];
      tick();
      if (i < 3) begin
        n_checks++;
        if (bus_a.write !== 1'b0) begin
          n_fail++; $display("FAIL single_early_write: got %b expected 0 (byte %0d)", bus_a.write, i);
        end
      end
    end
    bus_a.in_valid = 1'b0;
    n_checks++;
    if (bus_a.write !== 1'b1 || bus_a.write_addr !== 5'd0 || bus_a.write_data !== 32'h12345678) begin
      n_fail++;
      $display("FAIL single_write: got %b/%0d/%08h expected 1/0/12345678",
               bus_a.write, bus_a.write_addr, bus_a.write_data);
    end
    tick();
    n_checks++;
    if (bus_a.write !== 1'b0 || bus_a.write_data !== 32'h12345678) begin
      n_fail++;
      $display("FAIL single_hold: got %b/%08h expected 0/12345678", bus_a.write, bus_a.write_data);
    end
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;
  endtask

  task automatic test_full_run();
    int wr0;
    logic exp_w;
    instruction_t exp_word;
    wr0 = wr_cnt_a;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int i = 0; i < 128; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = byte_f(i);
      tick();
      exp_w = ((i % 4) == 3);
      n_checks++;
      if (bus_a.write !== exp_w) begin
        n_fail++; $display("FAIL full_write_strobe: got %b expected %b (byte %0d)", bus_a.write, exp_w, i);
      end
      if (exp_w) begin
        n_checks++;
        if (bus_a.write_addr !== 5'(i / 4)) begin
          n_fail++; $display("FAIL full_addr: got %0d expected %0d", bus_a.write_addr, i / 4);
        end
      end
    end
    // in_valid still high: DONE must refuse it
    n_checks++;
    if ({bus_a.done, bus_a.busy, bus_a.in_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL full_done: got done/busy/rdy=%b expected 100",
               {bus_a.done, bus_a.busy, bus_a.in_ready});
    end
    bus_a.in_valid = 1'b0;
    tick();
    n_checks++;
    if (wr_cnt_a - wr0 !== 32) begin
      n_fail++; $display("FAIL full_write_count: got %0d expected 32", wr_cnt_a - wr0);
    end
    for (int k = 0; k < 32; k++) begin
      exp_word = {byte_f(4*k+3), byte_f(4*k+2), byte_f(4*k+1), byte_f(4*k)};
      n_checks++;
      if (mem_a[k] !== exp_word) begin
        n_fail++; $display("FAIL full_readback: got %08h expected %08h (addr %0d)", mem_a[k], exp_word, k);
      end
    end
  endtask

  task automatic test_done_rerun();
    int wr0;
    wr0 = wr_cnt_a;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'h55;
    tick();
    tick();
    n_checks++;
    if ({bus_a.done, bus_a.in_ready, bus_a.write} !== 3'b100 || wr_cnt_a !== wr0) begin
      n_fail++;
      $display("FAIL done_hold: got done/rdy/wr=%b writes=%0d expected 100 writes=%0d",
               {bus_a.done, bus_a.in_ready, bus_a.write}, wr_cnt_a, wr0);
    end
    bus_a.in_valid = 1'b0;
    bus_a.start    = 1'b1;
    tick();
    bus_a.start = 1'b0;
    n_checks++;
    if ({bus_a.busy, bus_a.done} !== 2'b10) begin
      n_fail++; $display("FAIL rerun_state: got busy/done=%b expected 10", {bus_a.busy, bus_a.done});
    end
    for (int i = 0; i < 4; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 8'(i + 1);
      tick();
    end
    bus_a.in_valid = 1'b0;
    n_checks++;
    if (bus_a.write !== 1'b1 || bus_a.write_addr !== 5'd0 || bus_a.write_data !== 32'h04030201) begin
      n_fail++;
      $display("FAIL rerun_write: got %b/%0d/%08h expected 1/0/04030201",
               bus_a.write, bus_a.write_addr, bus_a.write_data);
    end
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;
  endtask

  task automatic test_abort();
    int wr0;
    logic [7:0] bs [4];
    bs = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    wr0 = wr_cnt_a;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 8'(8'h21 + i);
      tick();
    end
    // abort together with a valid byte and a start request
    bus_a.abort   = 1'b1;
    bus_a.start   = 1'b1;
    bus_a.in_data = 8'h27;
    #1;
    n_checks++;
    if (bus_a.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_ready: got %b expected 0", bus_a.in_ready);
    end
    tick();
    bus_a.abort    = 1'b0;
    bus_a.start    = 1'b0;
    bus_a.in_valid = 1'b0;
    n_checks++;
    if ({bus_a.busy, bus_a.done, bus_a.write} !== 3'b000) begin
      n_fail++; $display("FAIL abort_idle: got busy/done/wr=%b expected 000",
                         {bus_a.busy, bus_a.done, bus_a.write});
    end
    tick();
    tick();
    n_checks++;
    if (wr_cnt_a - wr0 !== 1 || mem_a[0] !== 32'h24232221) begin
      n_fail++; $display("FAIL abort_writes: got %0d writes, word0=%08h expected 1 write, 24232221",
                         wr_cnt_a - wr0, mem_a[0]);
    end
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = bs[i];
      tick();
    end
    bus_a.in_valid = 1'b0;
    n_checks++;
    if (bus_a.write !== 1'b1 || bus_a.write_addr !== 5'd0 || bus_a.write_data !== 32'hDDCCBBAA) begin
      n_fail++;
      $display("FAIL abort_restart: got %b/%0d/%08h expected 1/0/ddccbbaa",
               bus_a.write, bus_a.write_addr, bus_a.write_data);
    end
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;
  endtask

  task automatic test_be_midstart();
    logic [7:0] bs [8];
    bs = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h01, 8'h02, 8'h03, 8'h04};
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_b.start    = (i >= 2);   // held high mid-LOAD, must be ignored
      bus_b.in_valid = 1'b1;
      bus_b.in_data  = bs[i];
      tick();
      if (i == 3) begin
        n_checks++;
        if (bus_b.write !== 1'b1 || bus_b.write_addr !== 5'd0 || bus_b.write_data !== 32'h12345678) begin
          n_fail++;
          $display("FAIL be_word0: got %b/%0d/%08h expected 1/0/12345678",
                   bus_b.write, bus_b.write_addr, bus_b.write_data);
        end
      end
    end
    bus_b.start    = 1'b0;
    bus_b.in_valid = 1'b0;
    n_checks++;
    if (bus_b.write !== 1'b1 || bus_b.write_addr !== 5'd1 || bus_b.write_data !== 32'h01020304) begin
      n_fail++;
      $display("FAIL be_midstart_word1: got %b/%0d/%08h expected 1/1/01020304",
               bus_b.write, bus_b.write_addr, bus_b.write_data);
    end
    bus_b.abort = 1'b1;
    tick();
    bus_b.abort = 1'b0;
  endtask

  task automatic test_gaps();
    int wr0;
    int sent;
    logic [7:0] pat;
    instruction_t exp_words [4];
    exp_words = '{32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F};
    pat  = 8'b1011_0010;
    sent = 0;
    wr0  = wr_cnt_b;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    for (int c = 0; c < 64 && sent < 16; c++) begin
      bus_b.in_valid = pat[c % 8];
      bus_b.in_data  = pat[c % 8] ? 8'(8'h10 + sent) : 8'hEE;
      tick();
      if (pat[c % 8]) sent++;
    end
    bus_b.in_valid = 1'b0;
    tick();
    n_checks++;
    if (sent !== 16 || wr_cnt_b - wr0 !== 4) begin
      n_fail++; $display("FAIL gaps_count: got %0d bytes/%0d writes expected 16/4", sent, wr_cnt_b - wr0);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (mem_b[k] !== exp_words[k]) begin
        n_fail++; $display("FAIL gaps_data: got %08h expected %08h (addr %0d)", mem_b[k], exp_words[k], k);
      end
    end
    n_checks++;
    if (bus_b.done !== 1'b1) begin
      n_fail++; $display("FAIL gaps_done: got %b expected 1", bus_b.done);
    end
  endtask

  task automatic test_reset_mid();
    int wr_mid;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 8'(8'h31 + i);
      tick();
    end
    bus_a.in_valid = 1'b0;
    n_checks++;
    if (bus_a.write !== 1'b1 || bus_a.write_addr !== 5'd1 || bus_a.write_data !== 32'h38373635) begin
      n_fail++;
      $display("FAIL midreset_word1: got %b/%0d/%08h expected 1/1/38373635",
               bus_a.write, bus_a.write_addr, bus_a.write_data);
    end
    nrst = 1'b0;
    #1;
    n_checks++;
    if ({bus_a.in_ready, bus_a.write, bus_a.busy, bus_a.done} !== 4'b0
        || bus_a.write_addr !== 5'd0 || bus_a.write_data !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_async_a: got ctrl=%b addr=%0d data=%08h expected 0000/0/00000000",
               {bus_a.in_ready, bus_a.write, bus_a.busy, bus_a.done}, bus_a.write_addr, bus_a.write_data);
    end
    n_checks++;
    if (bus_b.done !== 1'b0) begin
      n_fail++; $display("FAIL midreset_async_b: got done=%b expected 0", bus_b.done);
    end
    wr_mid = wr_cnt_a;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'h40;
    tick();
    tick();
    nrst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({bus_a.in_ready, bus_a.busy} !== 2'b00 || wr_cnt_a !== wr_mid) begin
      n_fail++;
      $display("FAIL midreset_no_resume: got rdy/busy=%b writes=%0d expected 00 writes=%0d",
               {bus_a.in_ready, bus_a.busy}, wr_cnt_a, wr_mid);
    end
    bus_a.in_valid = 1'b0;
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_data = 8'h00;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_data = 8'h00;
    test_reset();
    test_single_word();
    test_full_run();
    test_done_rerun();
    test_abort();
    test_be_midstart();
    test_gaps();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
